alu: RTL and testbench
======================

# alu

Hack-style 16-bit arithmetic/logic unit with registered outputs. It sits in the CPU datapath between the operand sources (A/D registers, memory input) and the writeback/jump logic. The six control bits zx, nx, zy, ny, f and no select one of the Hack computations. The block produces the result plus zero (zr) and negative (ng) flags one clock after its inputs are sampled.

## Interface
- WIDTH, 16: operand/result width in bits; flags are always 1 bit.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  inputs are sampled this cycle.
- x  input  WIDTH  operand X (two's complement).
- y  input  WIDTH  operand Y (two's complement).
- zx  input  1  force X to 0.
- nx  input  1  bitwise-invert X (applied after zx).
- zy  input  1  force Y to 0.
- ny  input  1  bitwise-invert Y (applied after zy).
- f  input  1  1: X+Y; 0: X&Y.
- no  input  1  bitwise-invert the function result.
- out  output  WIDTH  registered result.
- zr  output  1  registered; 1 when out == 0.
- ng  output  1  registered; 1 when out is negative (out[WIDTH-1]).
- out_valid  output  1  registered in_valid; out, zr and ng are meaningful when 1.

## Operation
- Evaluation order:
  - x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1.
  - y1 = zy ? 0 : y; y2 = ny ? ~y1 : y1.
  - r = f ? (x2 + y2) : (x2 & y2).
  - res = no ? ~r : r.
- Addition is modulo 2^WIDTH; carry-out and overflow are discarded. No status is produced for them. Example: 0x7FFF + 1 = 0x8000, giving ng=1.
- zr = (res == 0); ng = res[WIDTH-1]. Both flags are computed from the final res, after no is applied.
- All 64 control combinations are legal. Combinations outside the Hack table still follow the equations above.
- Key encodings, written as zx nx zy ny f no:
  - 101010 → 0
  - 111111 → 1
  - 111010 → -1
  - 001100 → x
  - 110000 → y
  - 000010 → x+y
  - 010011 → x-y
  - 000111 → y-x
  - 000000 → x&y
  - 010101 → x|y

## Timing
- Latency is 1 cycle. Inputs present on edge N appear on out/zr/ng/out_valid after edge N.
- Throughput is one operation per cycle. There is no backpressure and no stall.
- in_valid=0: out, zr and ng hold their previous values. out_valid goes to 0 on the next edge.
- Reset (rst=1 at an edge) sets out=0, zr=1, ng=0, out_valid=0.
- Reset overrides in_valid in the same cycle. An operation sampled during reset is dropped.
- Release of reset: the first sample is taken on the first edge with rst=0 and in_valid=1.
- No combinational path from any input to any output.

## Structure
- Shared package alu_pkg:
  - ALU_W = 16.
  - Named 6-bit control constants for the encodings listed in Operation (e.g. ALU_ZERO, ALU_ONE, ALU_X_PLUS_Y, ALU_X_MINUS_Y).
  - A packed struct for the control bits {zx,nx,zy,ny,f,no}.
- Sub-module alu_core: purely combinational, parameterised by WIDTH. Implements the equations in Operation and produces res, zr and ng.
- The top level alu instantiates alu_core and holds only the output/valid registers and the reset logic.

## Test plan
- Reset: assert rst with in_valid=1 and arbitrary operands → after the edge, out=0, zr=1, ng=0, out_valid=0.
- x=9, y=15, sweep all 64 control combinations, one per cycle. Each result must match the equations one cycle later. Required values:
  - 000000 → 9
  - 000010 → 24
  - 000001 → -10
  - 000011 → -25
  - 111111 → 1
  - 010011 → -6
  - 000111 → 6
  - 010101 → 15
- Flags: x=9, y=15, ctrl 101010 → out=0, zr=1, ng=0. Ctrl 111010 → out=-1, zr=0, ng=1.
- Wrap-around: x=32767, y=1, ctrl 000010 → out=-32768, ng=1, zr=0. Then x=-1, y=1 → out=0, zr=1.
- Valid/hold: drive in_valid=1, 0, 1 with distinct operations.
  - out_valid must be 1, 0, 1, each one cycle delayed.
  - out must hold the first result during the gap.
- Mid-stream reset: assert rst for one cycle during back-to-back operations.
  - The result sampled in the reset cycle is lost.
  - The next operation appears normally one cycle after it is sampled.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the Hack-style ALU: operand width, control
// bit bundle and the named control encodings used by the datapath.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // Encodings written as {zx,nx,zy,ny,f,no}
    localparam logic [5:0] ALU_ZERO      = 6'b101010;
    localparam logic [5:0] ALU_ONE       = 6'b111111;
    localparam logic [5:0] ALU_NEG_ONE   = 6'b111010;
    localparam logic [5:0] ALU_X         = 6'b001100;
    localparam logic [5:0] ALU_Y         = 6'b110000;
    localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] ALU_Y_MINUS_X = 6'b000111;
    localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;
    localparam logic [5:0] ALU_X_OR_Y    = 6'b010101;

    function automatic alu_ctrl_t to_ctrl(input logic [5:0] bits);
        return alu_ctrl_t'(bits);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/control/result bundle between the operand sources and the ALU.
// The master drives operands and controls; the slave (the ALU) returns results.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             out_valid;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no,
        input  out, zr, ng, out_valid
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no,
        output out, zr, ng, out_valid
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational Hack ALU: operand preset/invert, add-or-and, optional
// output invert, and zero/negative flags taken from the final result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] r;

    assign x1 = ctrl.zx ? '0 : x;
    assign x2 = ctrl.nx ? ~x1 : x1;
    assign y1 = ctrl.zy ? '0 : y;
    assign y2 = ctrl.ny ? ~y1 : y1;

    // Sum is truncated to WIDTH; carry and overflow are intentionally dropped.
    assign r   = ctrl.f ? (x2 + y2) : (x2 & y2);
    assign res = ctrl.no ? ~r : r;

    assign zr = (res == '0);
    assign ng = res[WIDTH-1];

endmodule

// File: rtl/alu.sv
// Registered Hack ALU: one-cycle latency, one operation per cycle, results
// and flags hold while no new operation is sampled.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] res;
    logic             res_zr;
    logic             res_ng;

    assign ctrl = to_ctrl({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x    (bus.x),
        .y    (bus.y),
        .ctrl (ctrl),
        .res  (res),
        .zr   (res_zr),
        .ng   (res_ng)
    );

    // Reset wins over in_valid, so an operation sampled during reset is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out       <= '0;
            bus.zr        <= 1'b1;
            bus.ng        <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out <= res;
                bus.zr  <= res_zr;
                bus.ng  <= res_ng;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_if #(.WIDTH(16)) bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Independent integer model: ~v written as -v-1, masked at the end.
    function automatic logic [15:0] model(input int xv, input int yv, input logic [5:0] c);
        int a;
        int b;
        int r;
        a = c[5] ? 0 : xv;
        if (c[4]) a = -a - 1;
        b = c[3] ? 0 : yv;
        if (c[2]) b = -b - 1;
        r = c[1] ? (a + b) : (a & b);
        if (c[0]) r = -r - 1;
        return 16'(r & 32'hFFFF);
    endfunction

    // Hand-computed results for x=9, y=15; bit 16 marks a table hit.
    function automatic logic [16:0] hand(input logic [5:0] c);
        case (c)
            6'b000000: return {1'b1, 16'd9};
            6'b000010: return {1'b1, 16'd24};
            6'b000001: return {1'b1, 16'hFFF6};
            6'b000011: return {1'b1, 16'hFFE7};
            6'b111111: return {1'b1, 16'd1};
            6'b010011: return {1'b1, 16'hFFFA};
            6'b000111: return {1'b1, 16'd6};
            6'b010101: return {1'b1, 16'd15};
            6'b101010: return {1'b1, 16'd0};
            6'b111010: return {1'b1, 16'hFFFF};
            default:   return 17'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle; expectation queued only if the edge samples a live op.
    task automatic drive(input logic v, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [5:0] c, input logic [15:0] e, input string nm);
        exp_t it;
        bus.in_valid = v;
        bus.x  = xv;
        bus.y  = yv;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
        @(posedge clk);
        if (v && !rst) begin
            it.out  = e;
            it.zr   = (e == 16'd0);
            it.ng   = e[15];
            it.name = nm;
            sb.push_back(it);
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got out=%h, expected no output", bus.out);
                end else begin
                    e = sb.pop_front();
                    if (bus.out !== e.out || bus.zr !== e.zr || bus.ng !== e.ng) begin
                        n_fail++;
                        $display("FAIL %s: got out=%h zr=%b ng=%b, expected out=%h zr=%b ng=%b",
                                 e.name, bus.out, bus.zr, bus.ng, e.out, e.zr, e.ng);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [16:0] h;
        logic [15:0] e;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'd0;

        // Reset with a live operation present: it must be dropped.
        rst = 1'b1;
        drive(1'b1, 16'd1234, 16'd4321, ALU_X_PLUS_Y, 16'd0, "reset_op");
        chk("reset_out", bus.out, 16'd0);
        chk("reset_zr", {15'd0, bus.zr}, 16'd1);
        chk("reset_ng", {15'd0, bus.ng}, 16'd0);
        chk("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        rst = 1'b0;

        for (int c = 0; c < 64; c++) begin
            h = hand(6'(c));
            e = h[16] ? h[15:0] : model(9, 15, 6'(c));
            drive(1'b1, 16'd9, 16'd15, 6'(c), e, $sformatf("sweep_%06b", 6'(c)));
        end

        drive(1'b1, 16'd9, 16'd15, ALU_ZERO, 16'd0, "flag_zero");
        drive(1'b1, 16'd9, 16'd15, ALU_NEG_ONE, 16'hFFFF, "flag_neg_one");
        drive(1'b1, 16'd77, 16'd5, ALU_X, 16'd77, "pass_x");
        drive(1'b1, 16'd77, 16'd5, ALU_Y, 16'd5, "pass_y");
        drive(1'b1, 16'd7, 16'd10, ALU_Y_MINUS_X, 16'd3, "y_minus_x");

        drive(1'b1, 16'h7FFF, 16'd1, ALU_X_PLUS_Y, 16'h8000, "wrap_max");
        drive(1'b1, 16'hFFFF, 16'd1, ALU_X_PLUS_Y, 16'd0, "wrap_zero");

        // in_valid 1,0,1: result and flags must hold through the gap.
        drive(1'b1, 16'd20, 16'd4, ALU_X_PLUS_Y, 16'd24, "hold_first");
        chk("hold_valid_1", {15'd0, bus.out_valid}, 16'd1);
        drive(1'b0, 16'd3, 16'd3, ALU_X_AND_Y, 16'd0, "hold_gap");
        chk("hold_valid_0", {15'd0, bus.out_valid}, 16'd0);
        chk("hold_out", bus.out, 16'd24);
        chk("hold_zr", {15'd0, bus.zr}, 16'd0);
        chk("hold_ng", {15'd0, bus.ng}, 16'd0);
        drive(1'b1, 16'd20, 16'd4, ALU_X_MINUS_Y, 16'd16, "hold_second");
        chk("hold_valid_2", {15'd0, bus.out_valid}, 16'd1);

        // One-cycle reset inside a back-to-back stream.
        drive(1'b1, 16'd100, 16'd23, ALU_X_PLUS_Y, 16'd123, "mid_before");
        rst = 1'b1;
        drive(1'b1, 16'd5, 16'd5, ALU_X_PLUS_Y, 16'd10, "mid_dropped");
        rst = 1'b0;
        chk("mid_reset_out", bus.out, 16'd0);
        chk("mid_reset_valid", {15'd0, bus.out_valid}, 16'd0);
        drive(1'b1, 16'd50, 16'd8, ALU_X_MINUS_Y, 16'd42, "mid_after");
        drive(1'b1, 16'h00F0, 16'h0F0F, ALU_X_OR_Y, 16'h0FFF, "or_after");
        drive(1'b0, 16'd0, 16'd0, 6'd0, 16'd0, "idle");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        while (sb.size() != 0) begin
            exp_t lost;
            lost = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no output, expected out=%h", lost.name, lost.out);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
